decimal_entry_to_binary: RTL and testbench
==========================================

# decimal_entry_to_binary

Collects a decimal number typed one digit at a time on the 4-bit switch bank and converts it to a binary value. Each press of the enable button commits one BCD digit, most significant first. The entry ends when the finish button is pressed or the digit limit is reached. This is the input-side counterpart of the binary-to-seven-segment display path: its `valor`/`valido` outputs feed the register that the display block reads.

## Interface
- `MAX_DIGITS`, default 6: maximum number of digits per entry.
- `OUT_W`, default 20: width of the result. Must satisfy 2^OUT_W > 10^MAX_DIGITS − 1.
- `clk`, input, 1: system clock; all state changes on its rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `enable`, input, 1: digit-commit button, level input, synchronous to `clk`.
- `fin`, input, 1: end-of-entry button, level input, synchronous to `clk`.
- `sumar`, input, 4: BCD digit currently on the switches.
- `valor`, output, OUT_W: last completed result; held until the next completion.
- `valido`, output, 1: one-cycle pulse when `valor` is updated.
- `error`, output, 1: one-cycle pulse when a commit presents a digit greater than 9.
- `ocupado`, output, 1: high while an entry is in progress (state ≠ IDLE).
- `conteo`, output, 3: number of digits accepted in the current entry.

## Operation
- **Edge detection.** `enable_q` and `fin_q` are registered copies of `enable` and `fin`.
  - `rise_en = enable & ~enable_q`.
  - `rise_fin = fin & ~fin_q`.
  - Only rising edges act. A held button acts once.
- **Digit check.** On `rise_en`, a digit with `sumar` > 9 is rejected:
  - `error` pulses for one cycle.
  - The accumulator, `conteo` and the state are unchanged.
- **Accumulation.** `acc` is OUT_W bits. Each accepted digit gives `acc <= acc*10 + sumar`.
  - Implement ×10 as (acc<<3) + (acc<<1).
  - Because of the OUT_W constraint, the result cannot overflow.
- **State machine.** States are IDLE, CAPTURE and DONE.
  - **IDLE:** `acc` = 0 and `conteo` = 0.
    - A valid `rise_en` loads `acc <= sumar`, sets `conteo <= 1` and moves to CAPTURE.
    - If MAX_DIGITS = 1, it moves to DONE instead.
    - `rise_fin` is ignored.
  - **CAPTURE:**
    - A valid `rise_en` accumulates the digit and increments `conteo`. If the new `conteo` equals MAX_DIGITS, go to DONE.
    - `rise_fin` goes to DONE.
    - If a valid `rise_en` and `rise_fin` occur in the same cycle, the digit is included first, then go to DONE.
    - If an invalid `rise_en` and `rise_fin` occur in the same cycle, `error` pulses and the FSM goes to DONE with `acc` unchanged.
  - **DONE:** takes exactly one cycle.
    - `valor <= acc`, `valido <= 1`, go to IDLE.
    - `rise_en` and `rise_fin` are ignored in this cycle; a press here is lost.
- **Leading zeros.** Leading zeros count as digits. For example, 0,0,7 gives `valor` = 7 with `conteo` reaching 3.

## Timing
- **Reset values** (while `rst` = 0, asynchronous):
  - State = IDLE; `acc` = 0; `conteo` = 0; `valor` = 0.
  - `valido` = 0; `error` = 0; `ocupado` = 0.
  - `enable_q` = 1 and `fin_q` = 1, so a button held through reset release does not commit.
- **Reset mid-entry.** The partial entry is discarded. `valor` returns to 0 and no `valido` pulse is generated.
- **Digit commit.** Takes effect at the first clock edge that samples `enable` = 1 after it was 0. `conteo` and `acc` are visible after that edge.
- **Completion latency.**
  - Edge N commits the last digit (or samples `rise_fin`) and enters DONE.
  - Edge N+1 updates `valor` and raises `valido`.
  - Edge N+2 clears `valido`.
  - `valido` is high for exactly one cycle.
- **Error pulse.** `error` is registered: high for the one cycle after the offending edge.
- **`ocupado`.** Registered decode of the state. It is high in CAPTURE and DONE and falls with the return to IDLE.
- **New entries.** The next entry may begin on the first edge after the FSM returns to IDLE.

## Test plan
- **Four-digit entry.** Reset, then commit 1, 2, 3, 4 (one press each), then pulse `fin`.
  - `valor` = 1234 (0x004D2) and `valido` is a single one-cycle pulse.
  - `conteo` steps 1, 2, 3, 4.
- **Digit limit.** Commit 9 six times with no `fin`.
  - Auto-complete after the 6th digit: `valor` = 999999 (0xF423F).
  - `valido` rises 1 cycle after the 6th commit edge.
- **Invalid digit.** Commit 5, then `sumar` = 4'hC, then 3, then `fin`.
  - `error` pulses once on the 4'hC commit.
  - `valor` = 53 and `conteo` peaks at 2.
- **Simultaneous buttons and held button.**
  - Commit 4, then raise `enable` (with `sumar` = 2) and `fin` on the same edge: `valor` = 42.
  - Then hold `enable` high for 10 cycles: only one digit is accepted.
- **Reset behaviour.**
  - Commit 7, 8, then assert `rst` low: everything clears, `valor` = 0, no `valido`.
  - Release `rst` with `enable` held high: no commit until `enable` drops and rises again.
- **Idle finish.** `fin` in IDLE with no digits: no state change, no `valido`, `valor` unchanged from the previous result.

Source files
------------

// File: rtl/decimal_entry_to_binary.sv
// -----------------------------------------------------------------------------
// decimal_entry_to_binary
//
// Collects a decimal number entered one BCD digit at a time, most significant
// digit first. Each press of the commit button adds the switch digit, and the
// result is converted to binary as it is entered. An entry ends when the
// finish button is pressed or MAX_DIGITS digits have been accepted. The
// completed value is then published on valor together with a one-cycle valido
// pulse.
//
// Parameters
//   MAX_DIGITS : maximum digits per entry (1..7, limited by conteo's width)
//   OUT_W      : result width; 2**OUT_W must exceed 10**MAX_DIGITS - 1
//
// Ports
//   clk     : system clock, rising edge
//   rst     : asynchronous active-low reset
//   enable  : digit-commit button (level, synchronous to clk)
//   fin     : end-of-entry button (level, synchronous to clk)
//   sumar   : BCD digit on the switches
//   valor   : last completed result, held until the next completion
//   valido  : one-cycle pulse when valor updates
//   error   : one-cycle pulse when a commit presents a digit above 9
//   ocupado : high while an entry is in progress
//   conteo  : digits accepted in the current entry
// -----------------------------------------------------------------------------
module decimal_entry_to_binary #(
  parameter int MAX_DIGITS = 6,
  parameter int OUT_W      = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             fin,
  input  logic [3:0]       sumar,
  output logic [OUT_W-1:0] valor,
  output logic             valido,
  output logic             error,
  output logic             ocupado,
  output logic [2:0]       conteo
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state, state_n;
  logic             enable_q, fin_q;
  logic [OUT_W-1:0] acc, acc_n, valor_n;
  logic [2:0]       conteo_n;
  logic             valido_n, error_n;

  logic             rise_en, rise_fin, digit_ok, last_digit;
  logic [OUT_W-1:0] acc_next_digit;
  logic [2:0]       conteo_inc;

  assign rise_en  = enable & ~enable_q;
  assign rise_fin = fin & ~fin_q;
  assign digit_ok = (sumar <= 4'd9);

  // acc*10 + digit, with the multiply built from two shifts. OUT_W is sized so
  // that this cannot overflow for MAX_DIGITS digits.
  assign acc_next_digit = (acc << 3) + (acc << 1) + OUT_W'(sumar);
  assign conteo_inc     = conteo + 3'd1;
  assign last_digit     = (conteo_inc == 3'(MAX_DIGITS));

  // NOTE: every output of this block is given a default before the case
  // statement, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_n  = state;
    acc_n    = acc;
    conteo_n = conteo;
    valor_n  = valor;
    valido_n = 1'b0;
    error_n  = 1'b0;

    case (state)
      IDLE: begin
        // A finish press with no digits entered has nothing to complete.
        if (rise_en) begin
          if (digit_ok) begin
            acc_n    = OUT_W'(sumar);
            conteo_n = 3'd1;
            state_n  = (MAX_DIGITS == 1) ? DONE : CAPTURE;
          end else begin
            error_n = 1'b1;
          end
        end
      end

      CAPTURE: begin
        if (rise_en) begin
          if (digit_ok) begin
            acc_n    = acc_next_digit;
            conteo_n = conteo_inc;
            if (last_digit) state_n = DONE;
          end else begin
            error_n = 1'b1;
          end
        end
        // A digit committed on the same edge is already folded into acc_n.
        if (rise_fin) state_n = DONE;
      end

      DONE: begin
        // Button edges in this cycle are deliberately dropped.
        valor_n  = acc;
        valido_n = 1'b1;
        acc_n    = '0;
        conteo_n = 3'd0;
        state_n  = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      acc      <= '0;
      conteo   <= 3'd0;
      valor    <= '0;
      valido   <= 1'b0;
      error    <= 1'b0;
      ocupado  <= 1'b0;
      // NOTE: the edge detectors reset to 1 so a button already held when
      // reset is released does not look like a fresh press.
      enable_q <= 1'b1;
      fin_q    <= 1'b1;
    end else begin
      state    <= state_n;
      acc      <= acc_n;
      conteo   <= conteo_n;
      valor    <= valor_n;
      valido   <= valido_n;
      error    <= error_n;
      ocupado  <= (state_n != IDLE);
      enable_q <= enable;
      fin_q    <= fin;
    end
  end

endmodule

// File: tb/tb_decimal_entry_to_binary.sv
// -----------------------------------------------------------------------------
// tb_decimal_entry_to_binary
//
// Bench for decimal_entry_to_binary. A reference model keeps the digits of the
// current entry in a queue and evaluates the decimal number only when the
// entry completes. A compare process checks every DUT output against the
// model on each falling clock edge. Directed scenarios add hand-computed
// literal expectations, and a long random run follows them.
// -----------------------------------------------------------------------------
module tb_decimal_entry_to_binary;

  localparam int MAX_DIGITS = 6;
  localparam int OUT_W      = 20;

  logic             clk    = 1'b0;
  logic             rst    = 1'b1;
  logic             enable = 1'b0;
  logic             fin    = 1'b0;
  logic [3:0]       sumar  = 4'd0;
  logic [OUT_W-1:0] valor;
  logic             valido;
  logic             error;
  logic             ocupado;
  logic [2:0]       conteo;

  decimal_entry_to_binary #(
    .MAX_DIGITS(MAX_DIGITS),
    .OUT_W     (OUT_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .fin    (fin),
    .sumar  (sumar),
    .valor  (valor),
    .valido (valido),
    .error  (error),
    .ocupado(ocupado),
    .conteo (conteo)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the digits of the current entry are queued, and the value
  // is the ordinary base-10 evaluation of that queue at completion time.
  // ---------------------------------------------------------------------------
  int     m_digits[$];
  bit     m_prev_en   = 1'b1;
  bit     m_prev_fin  = 1'b1;
  bit     m_active    = 1'b0;   // an entry holds at least one digit
  bit     m_done_next = 1'b0;   // the entry completes on the next edge
  longint m_valor     = 0;
  bit     m_valido    = 1'b0;
  bit     m_error     = 1'b0;
  bit     m_re, m_rf, m_was_active;

  function automatic longint digits_value(input int q[$]);
    longint v = 0;
    foreach (q[i]) v = v * 10 + q[i];
    return v;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_digits.delete();
        m_prev_en   = 1'b1;
        m_prev_fin  = 1'b1;
        m_active    = 1'b0;
        m_done_next = 1'b0;
        m_valor     = 0;
        m_valido    = 1'b0;
        m_error     = 1'b0;
      end else begin
        m_re         = enable && !m_prev_en;
        m_rf         = fin && !m_prev_fin;
        m_prev_en    = enable;
        m_prev_fin   = fin;
        m_valido     = 1'b0;
        m_error      = 1'b0;
        m_was_active = m_active;
        if (m_done_next) begin
          m_valor     = digits_value(m_digits);
          m_valido    = 1'b1;
          m_digits.delete();
          m_done_next = 1'b0;
          m_active    = 1'b0;
        end else begin
          if (m_re) begin
            if (sumar > 4'd9) begin
              m_error = 1'b1;
            end else begin
              m_digits.push_back(int'(sumar));
              m_active = 1'b1;
              if (m_digits.size() == MAX_DIGITS) m_done_next = 1'b1;
            end
          end
          if (m_rf && m_was_active) m_done_next = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("valor",   valor,   m_valor);
      check("valido",  valido,  m_valido);
      check("error",   error,   m_error);
      check("ocupado", ocupado, m_active);
      check("conteo",  conteo,  m_digits.size());
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change just after the falling edge)
  // ---------------------------------------------------------------------------
  task automatic press(input logic [3:0] d);
    @(negedge clk); #1;
    sumar  = d;
    enable = 1'b1;
    @(negedge clk); #1;
    enable = 1'b0;
  endtask

  task automatic press_fin();
    @(negedge clk); #1;
    fin = 1'b1;
    @(negedge clk); #1;
    fin = 1'b0;
  endtask

  task automatic wait_valido(input string name, input longint exp, input int budget);
    bit found = 1'b0;
    for (int k = 0; k < budget && !found; k++) begin
      @(negedge clk);
      if (valido === 1'b1) begin
        found = 1'b1;
        check(name, valor, exp);
      end
    end
    if (!found) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: valido not seen within %0d cycles, expected valor %0d", name, budget, exp);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset, with a real falling edge on rst.
    #1 rst = 1'b0;
    #1;
    check("reset_valor",   valor,   0);
    check("reset_valido",  valido,  0);
    check("reset_error",   error,   0);
    check("reset_ocupado", ocupado, 0);
    check("reset_conteo",  conteo,  0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;

    // Four-digit entry: 1,2,3,4 then finish.
    for (int i = 1; i <= 4; i++) begin
      press(4'(i));
      check("four_conteo_step", conteo, i);
    end
    press_fin();
    wait_valido("four_digit_valor", 1234, 10);
    @(negedge clk);
    check("four_valido_single", valido, 0);

    // Digit limit: six nines auto-complete on the next edge.
    repeat (MAX_DIGITS) press(4'd9);
    wait_valido("limit_valor", 999999, 1);

    // Invalid digit in the middle of an entry.
    press(4'd5);
    press(4'hC);
    check("invalid_error_pulse", error, 1);
    check("invalid_conteo_kept", conteo, 1);
    press(4'd3);
    check("invalid_conteo_peak", conteo, 2);
    press_fin();
    wait_valido("invalid_valor", 53, 10);

    // Digit and finish on the same edge.
    press(4'd4);
    @(negedge clk); #1;
    sumar  = 4'd2;
    enable = 1'b1;
    fin    = 1'b1;
    @(negedge clk); #1;
    enable = 1'b0;
    fin    = 1'b0;
    wait_valido("simultaneous_valor", 42, 10);

    // Held button commits only once.
    @(negedge clk); #1;
    sumar  = 4'd5;
    enable = 1'b1;
    repeat (10) @(negedge clk);
    check("held_conteo", conteo, 1);
    #1 enable = 1'b0;
    press_fin();
    wait_valido("held_valor", 5, 10);

    // Reset mid-entry, with enable held through the reset release.
    press(4'd7);
    press(4'd8);
    @(negedge clk); #2;
    rst    = 1'b0;
    enable = 1'b1;
    #1;
    check("midreset_valor",   valor,   0);
    check("midreset_conteo",  conteo,  0);
    check("midreset_ocupado", ocupado, 0);
    check("midreset_valido",  valido,  0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("held_through_reset_conteo",  conteo,  0);
    check("held_through_reset_ocupado", ocupado, 0);
    #1 enable = 1'b0;
    press(4'd3);
    press_fin();
    wait_valido("after_reset_valor", 3, 10);

    // Finish pressed while idle: nothing happens.
    press_fin();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_fin_no_valido", valido, 0);
    end
    check("idle_fin_valor_kept", valor, 3);
    check("idle_fin_ocupado",    ocupado, 0);

    // Random run, including one asynchronous reset mid-stream.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      enable = ($urandom_range(0, 2) == 0);
      fin    = ($urandom_range(0, 9) == 0);
      sumar  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15))
                                           : 4'($urandom_range(0, 9));
      if (i == 1500) begin
        #1 rst = 1'b0;
        #1 rst = 1'b1;
      end
    end
    @(negedge clk); #1;
    enable = 1'b0;
    fin    = 1'b0;
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
